// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multi-cycle MIPS datapath: one state per cycle,
// stalls on mem_ready, sticky halt on illegal decode or memory timeout. Macro PERF_CNT_EN adds perf counters.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int ST_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic       WDInp,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc,
  output logic       illegal,
  output logic       timeout
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [ST_W-1:0] {
    S_IF, S_ID, S_EXR, S_WBR, S_EXI, S_WBI, S_MADR, S_MRD,
    S_WBL, S_MWR, S_BR, S_J, S_JAL, S_JR, S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait;
  logic [CNT_W-1:0] w_wait_nxt;
  logic             r_illegal;
  logic             r_timeout;
  logic             w_wait_step;
  logic             w_set_ill;
  logic             w_set_to;

  function automatic logic [2:0] f_alu_r(input logic [5:0] fn);
    case (fn)
      6'b100010: f_alu_r = ALU_SUB;
      6'b100100: f_alu_r = ALU_AND;
      6'b100101: f_alu_r = ALU_OR;
      6'b101010: f_alu_r = ALU_SLT;
      default:   f_alu_r = ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] f_alu_i(input logic [5:0] op);
    case (op)
      6'b001010: f_alu_i = ALU_SLT;
      6'b001100: f_alu_i = ALU_AND;
      default:   f_alu_i = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IF;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wait    <= w_wait_nxt;
      r_illegal <= r_illegal | w_set_ill;
      r_timeout <= r_timeout | w_set_to;
    end
  end

  always_comb begin
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 2'b00;
    WDInp        = 1'b0;
    MemToReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOperation = ALU_AND;
    PCSrc        = 2'b00;
    w_next       = r_state;
    w_wait_nxt   = '0;
    w_wait_step  = 1'b0;
    w_set_ill    = 1'b0;
    w_set_to     = 1'b0;
    case (r_state)
      S_IF: begin
        MemRead      = 1'b1;
        ALUSrcB      = 2'b01;
        ALUOperation = ALU_ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_ID;
        end else begin
          w_wait_step = 1'b1;
        end
      end
      S_ID: begin
        ALUSrcB      = 2'b11;
        ALUOperation = ALU_ADD;
        case (opc)
          6'b000000: begin
            case (func)
              6'b100000, 6'b100010, 6'b100100,
              6'b100101, 6'b101010: w_next = S_EXR;
              6'b001000:            w_next = S_JR;
              default: begin
                w_next    = S_HALT;
                w_set_ill = 1'b1;
              end
            endcase
          end
          6'b001000, 6'b001010, 6'b001100: w_next = S_EXI;
          6'b100011, 6'b101011:            w_next = S_MADR;
          6'b000100, 6'b000101:            w_next = S_BR;
          6'b000010:                       w_next = S_J;
          6'b000011:                       w_next = S_JAL;
          default: begin
            w_next    = S_HALT;
            w_set_ill = 1'b1;
          end
        endcase
      end
      S_EXR: begin
        ALUSrcA      = 1'b1;
        ALUOperation = f_alu_r(func);
        w_next       = S_WBR;
      end
      S_WBR: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
        w_next   = S_IF;
      end
      S_EXI: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = f_alu_i(opc);
        w_next       = S_WBI;
      end
      S_WBI: begin
        RegWrite = 1'b1;
        w_next   = S_IF;
      end
      S_MADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = ALU_ADD;
        w_next       = (opc == 6'b101011) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) w_next = S_WBL;
        else           w_wait_step = 1'b1;
      end
      S_WBL: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_IF;
      end
      S_MWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) w_next = S_IF;
        else           w_wait_step = 1'b1;
      end
      S_BR: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALU_SUB;
        PCSrc        = 2'b01;
        PCWrite      = (opc == 6'b000100) ? zero : ~zero;
        w_next       = S_IF;
      end
      S_J: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        w_next  = S_IF;
      end
      S_JAL: begin
        PCSrc    = 2'b10;
        PCWrite  = 1'b1;
        RegDst   = 2'b10;
        WDInp    = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_IF;
      end
      S_JR: begin
        PCSrc   = 2'b11;
        PCWrite = 1'b1;
        w_next  = S_IF;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
    // Counter only survives while stalled in the same memory state.
    if (w_wait_step) begin
      if (r_wait == WAIT_LIM) begin
        w_next   = S_HALT;
        w_set_to = 1'b1;
      end else begin
        w_wait_nxt = r_wait + CNT_W'(1);
      end
    end
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign illegal = r_illegal;
  assign timeout = r_timeout;

`ifdef PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_retired_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else if (r_state != S_HALT) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_state != S_IF && w_next == S_IF)
        r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`endif

endmodule
